result_frame_tx: RTL
====================

# result_frame_tx

Parametrised UART result reporter for the recognition pipeline. It snapshots a bus of NUM_FIELDS result bytes on a configurable video frame and qualifies the snapshot as stable across consecutive frames. It then transmits one framed packet, HEAD byte followed by the fields in order, through an internal `uart_byte_tx`, and sends only when the qualified result changes. It replaces the fixed 17-byte sender and sits between the recognition stages and the board RS-232 pin.

## Interface
- NUM_FIELDS, 17: result bytes per packet (1..64)
- HEAD_BYTE, 8'h0a: first byte of every packet
- CAPTURE_FRAME, 3'd3: vpframe_cnt value on which snapshots are taken
- SEND_FRAME, 3'd0: vpframe_cnt value on which a send may start
- STABLE_FRAMES, 2: consecutive identical snapshots required (1..7)
- BAUD_SET, 3'd4: baud select passed to `uart_byte_tx`

Ports:
- pixelclk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- vpframe_cnt  in  3  frame phase counter
- i_vsync  in  1  vertical sync; its rising edge is the frame event
- result_bus  in  8*NUM_FIELDS  field k is at [8k+7:8k]; field 0 is sent first
- Rs232_Tx  out  1  serial line; reset value 1
- frame_busy  out  1  packet in progress; reset value 0
- frame_done  out  1  one-cycle pulse after the last byte's Tx_Done; reset value 0
- drop_pulse  out  1  one-cycle pulse when a send trigger is lost because the block is busy; reset value 0

## Operation
- Edge detect: `vs_pos = i_vsync & ~i_vsync_r`. i_vsync_r resets to 0.
- Capture event (`vs_pos && vpframe_cnt==CAPTURE_FRAME`):
  - snap <= result_bus.
  - stable_cnt <= (result_bus==snap) ? sat(stable_cnt+1, 7) : 1.
- Qualified: `stable_cnt>=STABLE_FRAMES && |snap && snap!=last_sent`.
- Send event (`vs_pos && vpframe_cnt==SEND_FRAME`) while qualified:
  - If IDLE: txbuf <= snap, last_sent <= snap, start the packet.
  - If not IDLE: drop_pulse for one cycle; last_sent is unchanged, so the result retries on the next send event.
- Capture and send on the same frame parameters: capture updates first, and the send uses the pre-update snap.
- FSM:
  - IDLE -> LOAD on accepted trigger.
  - LOAD: send_en=1 for one cycle with Data_Byte=byte[idx] -> WAIT.
  - WAIT: on Tx_Done, if idx==LAST go to DONE, else idx++ and go to LOAD.
  - DONE: frame_done=1 -> IDLE.
- Byte sequence: idx 0=HEAD_BYTE, idx 1..NUM_FIELDS = field idx-1, then optional checksum.
- idx width is $clog2(NUM_FIELDS+2). idx clears on IDLE.
- frame_busy = (state!=IDLE).
- txbuf is frozen for the whole packet; later captures never alter bytes in flight.
- Reset asserted mid-packet clears FSM, snap, txbuf, last_sent=0 and stable_cnt=0 immediately. The UART returns to idle-high; the partial byte is abandoned.

## Timing
- vs_pos is registered; the trigger is seen 1 cycle after the i_vsync rise.
- First send_en is 1 cycle after trigger acceptance.
- Each subsequent send_en is exactly 1 cycle after the previous byte's Tx_Done.
- frame_done is 1 cycle after the final Tx_Done.
- IDLE is reached on the cycle after frame_done; a new trigger is accepted from then on.
- Packet length: (NUM_FIELDS+1) bytes, plus 1 with checksum. Each byte takes one UART frame, so duration is (NUM_FIELDS+1+chk) × 10 bit periods + (NUM_FIELDS+1+chk) × 2 clocks.

## Configuration
- RESULT_TX_CHECKSUM_EN defined: one extra byte follows the last field. It equals XOR of all NUM_FIELDS field bytes, HEAD excluded. LAST=NUM_FIELDS+1.
- RESULT_TX_CHECKSUM_EN undefined: no checksum byte, LAST=NUM_FIELDS, and no XOR logic is built.

## Structure
- Shared package `result_tx_pkg`:
  - FSM state enum (IDLE, LOAD, WAIT, DONE).
  - Default HEAD_BYTE constant.
  - Stable-counter saturation constant 7.
- Sub-module: existing `uart_byte_tx`, one instance (`u_uart_byte_tx`), driven by send_en/Data_Byte/BAUD_SET.
- Packet sequencing, qualification and buffering live in this module; no further sub-modules.

## Test plan
- **Basic packet.** NUM_FIELDS=3, result_bus=24'h03_02_01 held for 2 capture frames, then a send event -> Rs232_Tx carries 0a,01,02,03 (plus 00 checksum if enabled); frame_done pulses once.
- **Stability gate.** Result alternates 0x11/0x22 every capture -> no packet. Holding 0x22 for 2 captures -> one packet.
- **Change filter.** Same stable result over 5 more send events -> no further packets. Result changes to 0x33, stable 2 frames -> one new packet.
- **All-zero suppression.** result_bus=0 stable for 4 frames -> no transmission.
- **Busy drop and retry.** NUM_FIELDS=17 at slow baud, so a send event occurs while busy with a new stable result -> drop_pulse=1. The new packet starts at the next send event after IDLE, and the in-flight bytes are unchanged.
- **Reset mid-packet.** Assert reset_n=0 during byte 5 -> Rs232_Tx=1, frame_busy=0 within 0 cycles. After release, the same stable result is re-sent because last_sent was cleared.

Source files
------------

// File: rtl/result_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : result_tx_pkg
// Brief  : Shared state encoding and constants for the result frame sender.
// Rev    : 1.0
// ============================================================================
package result_tx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_LOAD = 2'd1;
    localparam state_t c_ST_WAIT = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

    localparam logic [7:0] c_HEAD_BYTE_DEFAULT = 8'h0a;
    localparam logic [2:0] c_STABLE_SAT        = 3'd7;

    function automatic logic [2:0] stable_inc(input logic [2:0] cnt);
        return (cnt == c_STABLE_SAT) ? cnt : cnt + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module : result_frame_tx_if
// Brief  : Frame-timing, result bus and serial status signals of the reporter.
// Rev    : 1.0
// ============================================================================
interface result_frame_tx_if #(
    parameter int NUM_FIELDS = 17
);
    logic [2:0]              vpframe_cnt;
    logic                    i_vsync;
    logic [8*NUM_FIELDS-1:0] result_bus;
    logic                    Rs232_Tx;
    logic                    frame_busy;
    logic                    frame_done;
    logic                    drop_pulse;

    modport master (
        output vpframe_cnt, i_vsync, result_bus,
        input  Rs232_Tx, frame_busy, frame_done, drop_pulse
    );

    modport slave (
        input  vpframe_cnt, i_vsync, result_bus,
        output Rs232_Tx, frame_busy, frame_done, drop_pulse
    );
endinterface
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_byte_tx
// Brief  : 8N1 byte transmitter; bit period is 16 << (7 - Baud_set) clocks.
// Rev    : 1.0
// ============================================================================
module uart_byte_tx (
    input  wire logic       Clk,
    input  wire logic       Rst_n,
    input  wire logic [7:0] Data_Byte,
    input  wire logic       send_en,
    input  wire logic [2:0] Baud_set,
    output logic            Rs232_Tx,
    output logic            Tx_Done
);
    logic [15:0] w_last_div;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_bit_idx;
    logic [7:0]  r_data;
    logic        r_busy;
    logic        r_tx;
    logic        r_done;

    assign w_last_div = (16'd16 << (3'd7 - Baud_set)) - 16'd1;

    // bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (send_en) begin
                    r_busy    <= 1'b1;
                    r_data    <= Data_Byte;
                    r_bit_idx <= '0;
                    r_div_cnt <= '0;
                    r_tx      <= 1'b0;
                end
            end else if (r_div_cnt == w_last_div) begin
                r_div_cnt <= '0;
                if (r_bit_idx == 4'd9) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_tx   <= 1'b1;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : r_data[r_bit_idx[2:0]];
                end
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
        end
    end

    assign Rs232_Tx = r_tx;
    assign Tx_Done  = r_done;

endmodule
`default_nettype wire

// File: rtl/result_frame_tx.sv
`default_nettype none
// ============================================================================
// Module : result_frame_tx
// Brief  : Snapshots a stable result bus per video frame and sends changed
//          results as HEAD + fields (+ XOR checksum with RESULT_TX_CHECKSUM_EN).
// Rev    : 1.0
// ============================================================================
module result_frame_tx
    import result_tx_pkg::*;
#(
    parameter int         NUM_FIELDS    = 17,
    parameter logic [7:0] HEAD_BYTE     = c_HEAD_BYTE_DEFAULT,
    parameter logic [2:0] CAPTURE_FRAME = 3'd3,
    parameter logic [2:0] SEND_FRAME    = 3'd0,
    parameter int         STABLE_FRAMES = 2,
    parameter logic [2:0] BAUD_SET      = 3'd4
) (
    input wire logic           pixelclk,
    input wire logic           reset_n,
    result_frame_tx_if.slave   res_if
);
    localparam int c_IDX_W = $clog2(NUM_FIELDS + 2);
    localparam int c_BUS_W = 8 * NUM_FIELDS;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int c_LAST  = NUM_FIELDS + 1;
`else
    localparam int c_LAST  = NUM_FIELDS;
`endif
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_LAST);

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_BUS_W-1:0]   r_snap;
    logic [c_BUS_W-1:0]   r_txbuf;
    logic [c_BUS_W-1:0]   r_last_sent;
    logic [2:0]           r_stable_cnt;
    logic                 r_vsync_d;
    logic                 r_vs_pos;
    logic                 r_drop;
    logic                 w_capture;
    logic                 w_send;
    logic                 w_qualified;
    logic                 w_send_en;
    logic                 w_tx_done;
    logic [7:0]           w_data_byte;

    assign w_capture   = r_vs_pos && (res_if.vpframe_cnt == CAPTURE_FRAME);
    assign w_send      = r_vs_pos && (res_if.vpframe_cnt == SEND_FRAME);
    assign w_qualified = (r_stable_cnt >= 3'(STABLE_FRAMES)) && (|r_snap)
                         && (r_snap != r_last_sent);

`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0] w_chksum;
    always_comb begin
        w_chksum = 8'h00;
        for (int k = 0; k < NUM_FIELDS; k++)
            w_chksum = w_chksum ^ r_txbuf[8*k +: 8];
    end
`endif

    always_comb begin
        w_data_byte = HEAD_BYTE;
        for (int k = 0; k < NUM_FIELDS; k++)
            if (r_idx == c_IDX_W'(k + 1))
                w_data_byte = r_txbuf[8*k +: 8];
`ifdef RESULT_TX_CHECKSUM_EN
        if (r_idx == c_LAST_IDX)
            w_data_byte = w_chksum;
`endif
    end

    // Capture and send act on the same registered edge; non-blocking updates
    // make a coincident send use the pre-capture snapshot.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= '0;
            r_snap       <= '0;
            r_txbuf      <= '0;
            r_last_sent  <= '0;
            r_stable_cnt <= '0;
            r_vsync_d    <= 1'b0;
            r_vs_pos     <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_vsync_d <= res_if.i_vsync;
            r_vs_pos  <= res_if.i_vsync & ~r_vsync_d;
            r_drop    <= 1'b0;

            if (w_capture) begin
                r_snap       <= res_if.result_bus;
                r_stable_cnt <= (res_if.result_bus == r_snap) ? stable_inc(r_stable_cnt) : 3'd1;
            end

            if (w_send && w_qualified && (r_state != c_ST_IDLE))
                r_drop <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    r_idx <= '0;
                    if (w_send && w_qualified) begin
                        r_txbuf     <= r_snap;
                        r_last_sent <= r_snap;
                        r_state     <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: r_state <= c_ST_WAIT;
                c_ST_WAIT: begin
                    if (w_tx_done) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= c_ST_LOAD;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_send_en         = (r_state == c_ST_LOAD);
    assign res_if.frame_busy = (r_state != c_ST_IDLE);
    assign res_if.frame_done = (r_state == c_ST_DONE);
    assign res_if.drop_pulse = r_drop;

    uart_byte_tx u_uart_byte_tx (
        .Clk       (pixelclk),
        .Rst_n     (reset_n),
        .Data_Byte (w_data_byte),
        .send_en   (w_send_en),
        .Baud_set  (BAUD_SET),
        .Rs232_Tx  (res_if.Rs232_Tx),
        .Tx_Done   (w_tx_done)
    );

endmodule
`default_nettype wire
